multiply_8bits: RTL and testbench

Unsigned 8×8 → 16-bit multiplier with a registered product, used as the 8-bit arithmetic core in the datapath. Partial products are summed by an array of 8-bit carry-select adder rows. The result is captured on the clock. There is no handshake: a new operand pair may be presented every cycle.

---
 rtl/mult8_pkg.sv | 26 ++
 rtl/mult8_csa_row.sv | 26 ++
 rtl/multiply_8bits.sv | 74 +++++++
 tb/tb_multiply_8bits.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mult8_pkg.sv
// Shared widths, types and the 4-bit ripple helper for the 8x8 array multiplier.
package mult8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

  localparam prod_t RST_PRODUCT = '0;

  // 4-bit ripple-carry add; result bit 4 is the carry-out.
  function automatic logic [4:0] add4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic       c;
    logic [4:0] r;
    c = cin;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k] = a[k] ^ b[k] ^ c;
      c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    r[4] = c;
    return r;
  endfunction

endpackage

// File: rtl/mult8_csa_row.sv
// One 8-bit carry-select adder row: ripple lower nibble, upper nibble computed
// for both carry values and picked by the lower-nibble carry.
module mult8_csa_row
  import mult8_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum,
  output logic            cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo  = add4(a[3:0], b[3:0], cin);
    hi0 = add4(a[7:4], b[7:4], 1'b0);
    hi1 = add4(a[7:4], b[7:4], 1'b1);
  end

  assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/multiply_8bits.sv
// Unsigned 8x8 -> 16 array multiplier with registered product.
// Define MULTIPLY_8BITS_INREG_EN to also register the operands (2-cycle latency).
module multiply_8bits
  import mult8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [PROD_W-1:0] product,
  input  logic [OP_W-1:0]   inp1,
  input  logic [OP_W-1:0]   inp2
);

  op_t a_op;
  op_t b_op;

`ifdef MULTIPLY_8BITS_INREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_op <= '0;
      b_op <= '0;
    end else begin
      a_op <= inp1;
      b_op <= inp2;
    end
  end
`else
  assign a_op = inp1;
  assign b_op = inp2;
`endif

  logic [OP_W-1:0][OP_W-1:0] pp;
  logic [OP_W-1:0][OP_W-1:0] row_sum;
  logic [OP_W-1:0]           row_cout;
  prod_t                     prod_comb;

  always_comb begin
    pp = '0;
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = a_op & {OP_W{b_op[i]}};
    end
  end

  assign row_sum[0]  = pp[0];
  assign row_cout[0] = 1'b0;

  // Each row adds the next partial product to the running sum shifted right by one;
  // the bit shifted out is a finished product bit.
  for (genvar i = 1; i < OP_W; i++) begin : g_row
    mult8_csa_row u_row (
      .a    ({row_cout[i-1], row_sum[i-1][OP_W-1:1]}),
      .b    (pp[i]),
      .cin  (1'b0),
      .sum  (row_sum[i]),
      .cout (row_cout[i])
    );
  end

  always_comb begin
    prod_comb = '0;
    for (int i = 0; i < OP_W - 1; i++) begin
      prod_comb[i] = row_sum[i][0];
    end
    prod_comb[PROD_W-1:OP_W-1] = {row_cout[OP_W-1], row_sum[OP_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= RST_PRODUCT;
    end else begin
      product <= prod_comb;
    end
  end

endmodule

// File: tb/tb_multiply_8bits.sv
// Self-checking bench for multiply_8bits: directed table, async reset, hold,
// random and exhaustive sweeps against an edge-history reference model.
module tb_multiply_8bits;

`ifdef MULTIPLY_8BITS_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] product;
  logic [7:0]  inp1;
  logic [7:0]  inp2;

  int n_checks = 0;
  int n_fail   = 0;

  multiply_8bits dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .product (product),
    .inp1    (inp1),
    .inp2    (inp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: remember the product of the operands seen at every rising edge,
  // and the last edge index at which reset was (or became) active.
  int          edge_cnt = 0;
  int          last_rst = 0;
  logic [15:0] hist [int];

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    hist[edge_cnt] = 16'(int'(inp1) * int'(inp2));
    if (!rst_n) last_rst = edge_cnt;
  end

  always @(negedge rst_n) last_rst = edge_cnt;

  function automatic logic [15:0] model_exp();
    int idx;
    idx = edge_cnt - (LAT - 1);
    if (!rst_n || idx <= last_rst || !hist.exists(idx)) return 16'd0;
    return hist[idx];
  endfunction

  int toggles = 0;
  always @(product) toggles = toggles + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [9];

  task automatic run_table();
    for (int i = 0; i < 9 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) check($sformatf("table[%0d]", i - LAT), product, tbl[i-LAT].exp);
      if (i < 9) begin
        inp1 = tbl[i].a;
        inp2 = tbl[i].b;
      end
    end
  endtask

  initial begin
    int tog0;
    tbl[0] = '{8'd40,  8'd150, 16'd6000};
    tbl[1] = '{8'd10,  8'd150, 16'd1500};
    tbl[2] = '{8'd40,  8'd150, 16'd6000};
    tbl[3] = '{8'd255, 8'd255, 16'd65025};
    tbl[4] = '{8'd3,   8'd5,   16'd15};
    tbl[5] = '{8'd0,   8'd255, 16'd0};
    tbl[6] = '{8'd255, 8'd1,   16'd255};
    tbl[7] = '{8'd128, 8'd2,   16'd256};
    tbl[8] = '{8'd128, 8'd128, 16'd16384};

    rst_n = 1'b0;
    inp1  = 8'd40;
    inp2  = 8'd150;
    repeat (3) @(negedge clk);
    check("reset_hold", product, 16'd0);
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    check("reset_release", product, 16'd6000);

    run_table();

    // Asynchronous reset between edges while holding 65025.
    @(negedge clk);
    inp1 = 8'd255;
    inp2 = 8'd255;
    repeat (LAT) @(negedge clk);
    check("pre_async", product, 16'd65025);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_drop", product, 16'd0);
    @(negedge clk);
    check("async_hold", product, 16'd0);
    rst_n = 1'b1;
    run_table();

    // Hold stability.
    @(negedge clk);
    inp1 = 8'd3;
    inp2 = 8'd5;
    repeat (LAT) @(negedge clk);
    tog0 = toggles;
    for (int i = 0; i < 10; i++) begin
      check("hold_neg", product, 16'd15);
      @(posedge clk);
      #1 check("hold_pos", product, 16'd15);
      @(negedge clk);
    end
    check("hold_toggles", 16'(toggles - tog0), 16'd0);

    // Random stream with an occasional async reset pulse.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check("random", product, model_exp());
      inp1 = 8'($urandom_range(0, 255));
      inp2 = 8'($urandom_range(0, 255));
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1 check("random_rst", product, model_exp());
        #1 rst_n = 1'b1;
      end
    end

    // Exhaustive back-to-back sweep.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        @(negedge clk);
        check("sweep", product, model_exp());
        inp1 = 8'(a);
        inp2 = 8'(b);
      end
    end
    repeat (LAT) begin
      @(negedge clk);
      check("sweep_tail", product, model_exp());
    end
    check("sweep_last", product, 16'd65025);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
